// File: rtl/irq_sequencer_if.sv
// Interrupt sequencer port bundle: peripheral IRQ lines, enable-register write, and IF-stage handshake.
// No storage of its own; the slave side is the sequencer and the master side is the surrounding logic.
interface irq_sequencer_if #(
   parameter int N_IRQ = 4,
   parameter int ID_W  = 2
);
   logic [N_IRQ-1:0] irq_src;
   logic             irq_en_we;
   logic [N_IRQ-1:0] irq_en_wdata;
   logic             intr_ack;
   logic             intr_return;
   logic             alert;
   logic [ID_W-1:0]  irq_id;
   logic [N_IRQ-1:0] irq_en;
   logic [N_IRQ-1:0] pending;
   logic             busy;

   modport master (
      output irq_src, irq_en_we, irq_en_wdata, intr_ack, intr_return,
      input  alert, irq_id, irq_en, pending, busy
   );

   modport slave (
      input  irq_src, irq_en_we, irq_en_wdata, intr_ack, intr_return,
      output alert, irq_id, irq_en, pending, busy
   );
endinterface

// File: rtl/irq_sequencer.sv
// Edge-latching IRQ sequencer: rise -> pending next edge -> alert one edge later; IRQ_ROUNDROBIN_EN selects round-robin.
// Alert is held through any IF stall until intr_ack; further requests are held off until intr_return.
module irq_sequencer #(
   parameter int               N_IRQ    = 4,
   parameter int               ID_W     = 2,
   parameter logic [N_IRQ-1:0] EN_RESET = {N_IRQ{1'b1}}
) (
   input  logic            clk,
   input  logic            rst_n,
   irq_sequencer_if.slave  io_bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_ALERT   = 2'b01,
      ST_SERVICE = 2'b10
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [N_IRQ-1:0] r_src_q;
   logic [N_IRQ-1:0] r_pending;
   logic [N_IRQ-1:0] r_en;
   logic             r_alert;
   logic [ID_W-1:0]  r_irq_id;

   logic [N_IRQ-1:0] w_rise;
   logic [N_IRQ-1:0] w_cand;
   logic [N_IRQ-1:0] w_clr;
   logic             w_any;
   logic [ID_W-1:0]  w_sel;
   logic             w_alert_nxt;
   logic [ID_W-1:0]  w_id_nxt;

   assign w_rise = io_bus.irq_src & ~r_src_q;
   assign w_cand = r_pending & r_en;

`ifdef IRQ_ROUNDROBIN_EN
   logic [ID_W-1:0]    r_last_id;
   logic [2*N_IRQ-1:0] w_dbl;
   logic [N_IRQ-1:0]   w_rot;
   int                 w_off;

   // Rotate the candidates so the search origin (last_id+1) lands on bit 0.
   always_comb begin
      w_dbl = {w_cand, w_cand} >> (int'(r_last_id) + 1);
      w_rot = w_dbl[N_IRQ-1:0];
      w_any = |w_rot;
      w_off = 0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (w_rot[i]) w_off = i;
      end
      w_sel = ID_W'((int'(r_last_id) + 1 + w_off) % N_IRQ);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_id <= ID_W'(N_IRQ - 1);
      end else if (r_state == ST_ALERT && io_bus.intr_ack) begin
         r_last_id <= r_irq_id;
      end
   end
`else
   always_comb begin
      w_any = |w_cand;
      w_sel = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (w_cand[i]) w_sel = ID_W'(i);
      end
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_alert_nxt = r_alert;
      w_id_nxt    = r_irq_id;
      w_clr       = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_state_nxt = ST_ALERT;
               w_alert_nxt = 1'b1;
               w_id_nxt    = w_sel;
            end
         end
         ST_ALERT: begin
            if (io_bus.intr_ack) begin
               w_state_nxt = ST_SERVICE;
               w_alert_nxt = 1'b0;
               w_clr       = {{(N_IRQ-1){1'b0}}, 1'b1} << r_irq_id;
            end
         end
         ST_SERVICE: begin
            if (io_bus.intr_return) w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_alert_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A fresh rise on the bit being cleared wins, so that event is not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_src_q   <= '0;
         r_pending <= '0;
         r_en      <= EN_RESET;
         r_alert   <= 1'b0;
         r_irq_id  <= '0;
      end else begin
         r_src_q   <= io_bus.irq_src;
         r_pending <= (r_pending & ~w_clr) | w_rise;
         r_alert   <= w_alert_nxt;
         r_irq_id  <= w_id_nxt;
         if (io_bus.irq_en_we) r_en <= io_bus.irq_en_wdata;
      end
   end

   assign io_bus.alert   = r_alert;
   assign io_bus.irq_id  = r_irq_id;
   assign io_bus.irq_en  = r_en;
   assign io_bus.pending = r_pending;
   assign io_bus.busy    = (r_state == ST_ALERT) || (r_state == ST_SERVICE);

endmodule

// File: tb/tb_irq_sequencer.sv
// Bench for irq_sequencer: directed scenarios plus random traffic against an event-level model.
module tb_irq_sequencer;

   localparam int PH_IDLE    = 0;
   localparam int PH_ALERT   = 1;
   localparam int PH_SERVICE = 2;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   irq_sequencer_if #(.N_IRQ(4), .ID_W(2)) bus ();

   irq_sequencer #(.N_IRQ(4), .ID_W(2), .EN_RESET(4'hF)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: what the sequencer must be doing, tracked as request phase + event sets.
   logic [3:0] m_pend, m_en, m_prev;
   int         m_phase;
   logic       m_alert;
   logic [1:0] m_id;
   int         m_last;

   task automatic model_reset();
      m_pend  = 4'h0;
      m_en    = 4'hF;
      m_prev  = 4'h0;
      m_phase = PH_IDLE;
      m_alert = 1'b0;
      m_id    = 2'd0;
      m_last  = 3;
   endtask

   function automatic int pick(logic [3:0] c);
      int idx;
`ifdef IRQ_ROUNDROBIN_EN
      for (int k = 1; k <= 4; k++) begin
         idx = (m_last + k) % 4;
         if (c[idx[1:0]]) return idx;
      end
`else
      for (int i = 0; i < 4; i++) begin
         idx = i;
         if (c[idx[1:0]]) return idx;
      end
`endif
      return -1;
   endfunction

   task automatic model_update();
      logic [3:0] rise;
      logic [3:0] clr;
      int         s;
      if (!rst_n) begin
         model_reset();
         return;
      end
      rise = bus.irq_src & ~m_prev;
      clr  = 4'h0;
      if (m_phase == PH_IDLE) begin
         s = pick(m_pend & m_en);
         if (s >= 0) begin
            m_phase = PH_ALERT;
            m_alert = 1'b1;
            m_id    = 2'(s);
         end
      end else if (m_phase == PH_ALERT) begin
         if (bus.intr_ack) begin
            m_phase  = PH_SERVICE;
            m_alert  = 1'b0;
            clr[m_id] = 1'b1;
            m_last   = int'(m_id);
         end
      end else if (bus.intr_return) begin
         m_phase = PH_IDLE;
      end
      m_pend = (m_pend & ~clr) | rise;
      m_prev = bus.irq_src;
      if (bus.irq_en_we) m_en = bus.irq_en_wdata;
   endtask

   task automatic cmp(string name, int got, int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic check_all();
      cmp("alert",   int'(bus.alert),   int'(m_alert));
      cmp("irq_id",  int'(bus.irq_id),  int'(m_id));
      cmp("irq_en",  int'(bus.irq_en),  int'(m_en));
      cmp("pending", int'(bus.pending), int'(m_pend));
      cmp("busy",    int'(bus.busy),    (m_phase != PH_IDLE) ? 1 : 0);
   endtask

   // One clock: model advances on the edge, outputs checked on the falling edge.
   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_all();
   endtask

   task automatic ack_cycle();
      bus.intr_ack = 1'b1;
      step();
      bus.intr_ack = 1'b0;
   endtask

   task automatic ret_cycle();
      bus.intr_return = 1'b1;
      step();
      bus.intr_return = 1'b0;
   endtask

   initial begin
      vectors          = 0;
      miscompares      = 0;
      rst_n            = 1'b0;
      bus.irq_src      = 4'h0;
      bus.irq_en_we    = 1'b0;
      bus.irq_en_wdata = 4'h0;
      bus.intr_ack     = 1'b0;
      bus.intr_return  = 1'b0;
      model_reset();
      repeat (3) step();
      cmp("rst_alert",   int'(bus.alert),   0);
      cmp("rst_pending", int'(bus.pending), 0);
      cmp("rst_en",      int'(bus.irq_en),  15);
      cmp("rst_busy",    int'(bus.busy),    0);
      rst_n = 1'b1;
      step();

      // single pulse on bit 2
      bus.irq_src = 4'b0100;
      step();
      bus.irq_src = 4'b0000;
      cmp("t1_pending", int'(bus.pending), 4);
      cmp("t1_noalert", int'(bus.alert), 0);
      step();
      cmp("t1_alert", int'(bus.alert), 1);
      cmp("t1_id",    int'(bus.irq_id), 2);

      // alert held across a stalled IF
      repeat (5) begin
         step();
         cmp("t2_hold", int'(bus.alert), 1);
      end
      ack_cycle();
      cmp("t2_alert_low", int'(bus.alert), 0);
      cmp("t2_pend_clr",  int'(bus.pending), 0);
      repeat (3) begin
         step();
         cmp("t2_busy", int'(bus.busy), 1);
      end
      ret_cycle();
      cmp("t2_idle", int'(bus.busy), 0);

      // simultaneous rise on bits 1 and 3
      bus.irq_src = 4'b1010;
      step();
      bus.irq_src = 4'b0000;
      step();
      cmp("t3_first", int'(bus.irq_id), 1);
      ack_cycle();
      cmp("t3_left", int'(bus.pending), 8);
      ret_cycle();
      cmp("t3_gap", int'(bus.alert), 0);
      step();
      cmp("t3_second_alert", int'(bus.alert), 1);
      cmp("t3_second", int'(bus.irq_id), 3);
      ack_cycle();
      ret_cycle();

      // masked source becomes eligible after the enable write
      bus.irq_en_we = 1'b1;
      bus.irq_en_wdata = 4'b0111;
      step();
      bus.irq_en_we = 1'b0;
      cmp("t4_en", int'(bus.irq_en), 7);
      bus.irq_src = 4'b1000;
      step();
      bus.irq_src = 4'b0000;
      cmp("t4_pend", int'(bus.pending), 8);
      repeat (3) begin
         step();
         cmp("t4_masked", int'(bus.alert), 0);
      end
      bus.irq_en_we = 1'b1;
      bus.irq_en_wdata = 4'b1111;
      step();
      bus.irq_en_we = 1'b0;
      cmp("t4_not_yet", int'(bus.alert), 0);
      step();
      cmp("t4_alert", int'(bus.alert), 1);
      cmp("t4_id", int'(bus.irq_id), 3);
      ack_cycle();
      ret_cycle();

      // new rise on the acknowledged bit is kept
      bus.irq_src = 4'b0001;
      step();
      bus.irq_src = 4'b0000;
      step();
      cmp("t5_id0", int'(bus.irq_id), 0);
      bus.irq_src = 4'b0001;
      ack_cycle();
      bus.irq_src = 4'b0000;
      cmp("t5_kept", int'(bus.pending), 1);
      ret_cycle();
      step();
      cmp("t5_realert", int'(bus.alert), 1);
      cmp("t5_reid", int'(bus.irq_id), 0);
      ack_cycle();
      ret_cycle();

      // asynchronous reset while in SERVICE
      bus.irq_src = 4'b0110;
      step();
      bus.irq_src = 4'b0000;
      step();
      ack_cycle();
      cmp("t6_svc_busy", int'(bus.busy), 1);
      cmp("t6_svc_pend", int'(bus.pending), 4);
      rst_n = 1'b0;
      #1;
      model_reset();
      cmp("t6_rst_busy", int'(bus.busy), 0);
      cmp("t6_rst_pend", int'(bus.pending), 0);
      cmp("t6_rst_id",   int'(bus.irq_id), 0);
      check_all();
      step();
      rst_n = 1'b1;

`ifdef IRQ_ROUNDROBIN_EN
      bus.irq_src = 4'b0011;
      step();
      bus.irq_src = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         step();
         cmp("rr_id", int'(bus.irq_id), i % 2);
         bus.irq_src = 4'b0011;
         ack_cycle();
         bus.irq_src = 4'b0000;
         ret_cycle();
      end
`endif

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         bus.irq_src      = 4'($urandom & $urandom & $urandom);
         bus.irq_en_we    = ($urandom_range(0, 15) == 0);
         bus.irq_en_wdata = 4'($urandom);
         bus.intr_ack     = ($urandom_range(0, 2) == 0);
         bus.intr_return  = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
            #1;
            model_reset();
            check_all();
            step();
            rst_n = 1'b1;
         end else begin
            step();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
